// File: rtl/reg_file_sb_pkg.sv
// rtl/reg_file_sb_pkg.sv - shared widths and types for the register file / scoreboard slice
package reg_file_sb_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int NUM_REGS       = 32;
  localparam int REG_ADDR_WIDTH = $clog2(NUM_REGS);

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0]     reg_data_t;

endpackage

// File: rtl/reg_file_sb_if.sv
// rtl/reg_file_sb_if.sv - issue/read/write-back bus between decode, alu_math and reg_file_sb
interface reg_file_sb_if;
  import reg_file_sb_pkg::*;

  reg_addr_t rs1_addr_i;
  reg_addr_t rs2_addr_i;
  reg_data_t rs1_data_o;
  reg_data_t rs2_data_o;
  logic      issue_valid_i;
  reg_addr_t issue_rd_i;
  logic      issue_ready_o;
  logic      wb_valid_i;
  reg_addr_t wb_rd_i;
  reg_data_t wb_data_i;
  logic      wb_err_o;

  modport master (
    output rs1_addr_i, rs2_addr_i, issue_valid_i, issue_rd_i,
    output wb_valid_i, wb_rd_i, wb_data_i,
    input  rs1_data_o, rs2_data_o, issue_ready_o, wb_err_o
  );

  modport slave (
    input  rs1_addr_i, rs2_addr_i, issue_valid_i, issue_rd_i,
    input  wb_valid_i, wb_rd_i, wb_data_i,
    output rs1_data_o, rs2_data_o, issue_ready_o, wb_err_o
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// rtl/reg_file_sb_scoreboard.sv - busy bits, pending counter, hazard check and wb error pulse
// REG_FILE_SB_BYPASS_EN: a write-back in flight this cycle hides its busy bit from the hazard check.
module reg_scoreboard #(
  parameter int NUM_REGS = reg_file_sb_pkg::NUM_REGS
) (
  input  logic                        clk_i,
  input  logic                        arst_ni,
  input  logic [$clog2(NUM_REGS)-1:0] rs1_addr,
  input  logic [$clog2(NUM_REGS)-1:0] rs2_addr,
  input  logic                        issue_valid,
  input  logic [$clog2(NUM_REGS)-1:0] issue_rd,
  output logic                        issue_ready,
  input  logic                        wb_valid,
  input  logic [$clog2(NUM_REGS)-1:0] wb_rd,
  input  logic                        wb_data_nz,
  output logic [NUM_REGS-1:0]         busy,
  output logic [$clog2(NUM_REGS):0]   pending,
  output logic                        wb_err
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0] busy_haz;
  logic [NUM_REGS-1:0] busy_d;
  logic                haz;
  logic                set_en;
  logic                clr_en;

  always_comb begin
    busy_haz = busy;
`ifdef REG_FILE_SB_BYPASS_EN
    if (wb_valid) busy_haz[wb_rd] = 1'b0;
`endif
    haz = busy_haz[rs1_addr] | busy_haz[rs2_addr] | busy_haz[issue_rd];
  end

  assign issue_ready = ~haz;
  assign set_en      = issue_valid & ~haz & (issue_rd != '0);
  // Only a genuinely reserved destination retires, so the counter can never underflow.
  assign clr_en      = wb_valid & (wb_rd != '0) & busy[wb_rd];

  // Clear before set: a same-cycle retire and re-reserve of one rd leaves it busy.
  always_comb begin
    busy_d = busy;
    if (clr_en) busy_d[wb_rd] = 1'b0;
    if (set_en) busy_d[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      busy    <= '0;
      pending <= '0;
      wb_err  <= 1'b0;
    end else begin
      busy <= busy_d;
      case ({set_en, clr_en})
        2'b10:   pending <= pending + (AW+1)'(1);
        2'b01:   pending <= pending - (AW+1)'(1);
        default: pending <= pending;
      endcase
      wb_err <= wb_valid & ((wb_rd != '0) ? ~busy[wb_rd] : wb_data_nz);
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with write-back scoreboard feeding alu_math operands
// REG_FILE_SB_BYPASS_EN: forward same-cycle write-back data onto rs1/rs2 reads (r0 excluded).
module reg_file_sb #(
  parameter int NUM_REGS = reg_file_sb_pkg::NUM_REGS,
  parameter int DW       = reg_file_sb_pkg::DATA_WIDTH
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  reg_file_sb_if.slave              bus,
  output logic [NUM_REGS-1:0]       busy_o,
  output logic [$clog2(NUM_REGS):0] pending_o
);
  import reg_file_sb_pkg::*;

  logic [DW-1:0] regs [NUM_REGS];
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (bus.wb_valid_i && (bus.wb_rd_i != '0)) begin
      regs[bus.wb_rd_i] <= bus.wb_data_i;
    end
  end

  always_comb begin
    rs1_data = (bus.rs1_addr_i == '0) ? '0 : regs[bus.rs1_addr_i];
`ifdef REG_FILE_SB_BYPASS_EN
    if (bus.wb_valid_i && (bus.wb_rd_i == bus.rs1_addr_i) && (bus.rs1_addr_i != '0))
      rs1_data = bus.wb_data_i;
`endif
  end

  always_comb begin
    rs2_data = (bus.rs2_addr_i == '0) ? '0 : regs[bus.rs2_addr_i];
`ifdef REG_FILE_SB_BYPASS_EN
    if (bus.wb_valid_i && (bus.wb_rd_i == bus.rs2_addr_i) && (bus.rs2_addr_i != '0))
      rs2_data = bus.wb_data_i;
`endif
  end

  assign bus.rs1_data_o = rs1_data;
  assign bus.rs2_data_o = rs2_data;

  reg_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .rs1_addr    (bus.rs1_addr_i),
    .rs2_addr    (bus.rs2_addr_i),
    .issue_valid (bus.issue_valid_i),
    .issue_rd    (bus.issue_rd_i),
    .issue_ready (bus.issue_ready_o),
    .wb_valid    (bus.wb_valid_i),
    .wb_rd       (bus.wb_rd_i),
    .wb_data_nz  (|bus.wb_data_i),
    .busy        (busy_o),
    .pending     (pending_o),
    .wb_err      (bus.wb_err_o)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - self-checking bench for reg_file_sb (expectations follow REG_FILE_SB_BYPASS_EN)
module tb_reg_file_sb;
  import reg_file_sb_pkg::*;

  logic        clk_i   = 1'b0;
  logic        arst_ni = 1'b0;
  logic [31:0] busy_o;
  logic [5:0]  pending_o;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_q [$];

  reg_file_sb_if bus ();

  reg_file_sb dut (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .bus       (bus),
    .busy_o    (busy_o),
    .pending_o (pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle;
    bus.issue_valid_i = 1'b0;
    bus.issue_rd_i    = '0;
    bus.rs1_addr_i    = '0;
    bus.rs2_addr_i    = '0;
    bus.wb_valid_i    = 1'b0;
    bus.wb_rd_i       = '0;
    bus.wb_data_i     = '0;
  endtask

  task automatic test_reset;
    logic [31:0] e;
    idle();
    arst_ni = 1'b0;
    #12;
    arst_ni = 1'b1;
    tick();
    n_cmp++; if (busy_o !== 32'h0) begin n_bad++; $display("FAIL reset_busy got=%h exp=0", busy_o); end
    n_cmp++; if (pending_o !== 6'd0) begin n_bad++; $display("FAIL reset_pending got=%0d exp=0", pending_o); end
    n_cmp++; if (bus.issue_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", bus.issue_ready_o); end
    n_cmp++; if (bus.wb_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_wb_err got=%b exp=0", bus.wb_err_o); end
    for (int r = 0; r < 32; r++) begin
      bus.rs1_addr_i = 5'(r);
      bus.rs2_addr_i = 5'(31 - r);
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h0);
      #2;
      e = exp_q.pop_front();
      n_cmp++; if (bus.rs1_data_o !== e) begin n_bad++; $display("FAIL reset_rs1 r%0d got=%h exp=%h", r, bus.rs1_data_o, e); end
      e = exp_q.pop_front();
      n_cmp++; if (bus.rs2_data_o !== e) begin n_bad++; $display("FAIL reset_rs2 r%0d got=%h exp=%h", 31 - r, bus.rs2_data_o, e); end
      tick();
    end
  endtask

  task automatic test_wb_unreserved;
    logic [31:0] e;
    idle();
    bus.wb_valid_i = 1'b1;
    bus.wb_rd_i    = 5'd5;
    bus.wb_data_i  = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    tick();
    idle();
    bus.rs1_addr_i = 5'd5;
    #2;
    n_cmp++; if (bus.wb_err_o !== 1'b1) begin n_bad++; $display("FAIL unres_wb_err got=%b exp=1", bus.wb_err_o); end
    e = exp_q.pop_front();
    n_cmp++; if (bus.rs1_data_o !== e) begin n_bad++; $display("FAIL unres_read got=%h exp=%h", bus.rs1_data_o, e); end
    tick();
    n_cmp++; if (bus.wb_err_o !== 1'b0) begin n_bad++; $display("FAIL unres_err_len got=%b exp=0", bus.wb_err_o); end
  endtask

  task automatic test_issue_hazard;
    logic [31:0] e;
    idle();
    bus.issue_rd_i    = 5'd3;
    bus.issue_valid_i = 1'b1;
    #2;
    n_cmp++; if (bus.issue_ready_o !== 1'b1) begin n_bad++; $display("FAIL haz_first_ready got=%b exp=1", bus.issue_ready_o); end
    tick();
    bus.issue_valid_i = 1'b0;
    n_cmp++; if (busy_o[3] !== 1'b1) begin n_bad++; $display("FAIL haz_busy3 got=%b exp=1", busy_o[3]); end
    n_cmp++; if (pending_o !== 6'd1) begin n_bad++; $display("FAIL haz_pending got=%0d exp=1", pending_o); end
    bus.rs1_addr_i    = 5'd3;
    bus.issue_rd_i    = 5'd1;
    bus.issue_valid_i = 1'b1;
    #2;
    n_cmp++; if (bus.issue_ready_o !== 1'b0) begin n_bad++; $display("FAIL haz_raw_ready got=%b exp=0", bus.issue_ready_o); end
    tick();
    n_cmp++; if (busy_o !== 32'h0000_0008) begin n_bad++; $display("FAIL haz_stall_busy got=%h exp=00000008", busy_o); end
    bus.issue_valid_i = 1'b0;
    bus.wb_valid_i    = 1'b1;
    bus.wb_rd_i       = 5'd3;
    bus.wb_data_i     = 32'h7;
`ifdef REG_FILE_SB_BYPASS_EN
    exp_q.push_back(32'h7);
    #2;
    n_cmp++; if (bus.issue_ready_o !== 1'b1) begin n_bad++; $display("FAIL haz_wb_ready got=%b exp=1", bus.issue_ready_o); end
`else
    exp_q.push_back(32'h0);
    #2;
    n_cmp++; if (bus.issue_ready_o !== 1'b0) begin n_bad++; $display("FAIL haz_wb_ready got=%b exp=0", bus.issue_ready_o); end
`endif
    e = exp_q.pop_front();
    n_cmp++; if (bus.rs1_data_o !== e) begin n_bad++; $display("FAIL haz_wb_rs1 got=%h exp=%h", bus.rs1_data_o, e); end
    tick();
    bus.wb_valid_i = 1'b0;
    exp_q.push_back(32'h7);
    #2;
    n_cmp++; if (busy_o[3] !== 1'b0) begin n_bad++; $display("FAIL haz_clear got=%b exp=0", busy_o[3]); end
    n_cmp++; if (pending_o !== 6'd0) begin n_bad++; $display("FAIL haz_pending0 got=%0d exp=0", pending_o); end
    n_cmp++; if (bus.wb_err_o !== 1'b0) begin n_bad++; $display("FAIL haz_wb_err got=%b exp=0", bus.wb_err_o); end
    n_cmp++; if (bus.issue_ready_o !== 1'b1) begin n_bad++; $display("FAIL haz_after_ready got=%b exp=1", bus.issue_ready_o); end
    e = exp_q.pop_front();
    n_cmp++; if (bus.rs1_data_o !== e) begin n_bad++; $display("FAIL haz_after_rs1 got=%h exp=%h", bus.rs1_data_o, e); end
    tick();
  endtask

  task automatic test_r0;
    logic [31:0] e;
    idle();
    bus.wb_valid_i = 1'b1;
    bus.wb_rd_i    = 5'd0;
    bus.wb_data_i  = 32'h1234;
    exp_q.push_back(32'h0);
    #2;
    e = exp_q.pop_front();
    n_cmp++; if (bus.rs1_data_o !== e) begin n_bad++; $display("FAIL r0_wb_cycle got=%h exp=%h", bus.rs1_data_o, e); end
    tick();
    idle();
    exp_q.push_back(32'h0);
    bus.issue_valid_i = 1'b1;
    #2;
    n_cmp++; if (bus.wb_err_o !== 1'b1) begin n_bad++; $display("FAIL r0_wb_err got=%b exp=1", bus.wb_err_o); end
    e = exp_q.pop_front();
    n_cmp++; if (bus.rs1_data_o !== e) begin n_bad++; $display("FAIL r0_read got=%h exp=%h", bus.rs1_data_o, e); end
    n_cmp++; if (bus.issue_ready_o !== 1'b1) begin n_bad++; $display("FAIL r0_ready got=%b exp=1", bus.issue_ready_o); end
    tick();
    idle();
    n_cmp++; if (busy_o !== 32'h0) begin n_bad++; $display("FAIL r0_busy got=%h exp=0", busy_o); end
    n_cmp++; if (pending_o !== 6'd0) begin n_bad++; $display("FAIL r0_pending got=%0d exp=0", pending_o); end
    n_cmp++; if (bus.wb_err_o !== 1'b0) begin n_bad++; $display("FAIL r0_err_len got=%b exp=0", bus.wb_err_o); end
  endtask

  task automatic test_same_rd;
    logic [31:0] e;
    idle();
    bus.issue_rd_i    = 5'd4;
    bus.issue_valid_i = 1'b1;
    tick();
    bus.issue_valid_i = 1'b0;
    n_cmp++; if (pending_o !== 6'd1) begin n_bad++; $display("FAIL same_pending_pre got=%0d exp=1", pending_o); end
    bus.issue_valid_i = 1'b1;
    bus.wb_valid_i    = 1'b1;
    bus.wb_rd_i       = 5'd4;
    bus.wb_data_i     = 32'h44;
    #2;
`ifdef REG_FILE_SB_BYPASS_EN
    n_cmp++; if (bus.issue_ready_o !== 1'b1) begin n_bad++; $display("FAIL same_ready got=%b exp=1", bus.issue_ready_o); end
    tick();
    idle();
    n_cmp++; if (busy_o !== 32'h0000_0010) begin n_bad++; $display("FAIL same_busy got=%h exp=00000010", busy_o); end
    n_cmp++; if (pending_o !== 6'd1) begin n_bad++; $display("FAIL same_pending got=%0d exp=1", pending_o); end
    n_cmp++; if (bus.wb_err_o !== 1'b0) begin n_bad++; $display("FAIL same_wb_err got=%b exp=0", bus.wb_err_o); end
    bus.wb_valid_i = 1'b1;
    bus.wb_rd_i    = 5'd4;
    bus.wb_data_i  = 32'h45;
    exp_q.push_back(32'h45);
    tick();
    idle();
`else
    n_cmp++; if (bus.issue_ready_o !== 1'b0) begin n_bad++; $display("FAIL same_ready got=%b exp=0", bus.issue_ready_o); end
    exp_q.push_back(32'h44);
    tick();
    idle();
    n_cmp++; if (bus.wb_err_o !== 1'b0) begin n_bad++; $display("FAIL same_wb_err got=%b exp=0", bus.wb_err_o); end
`endif
    bus.rs1_addr_i = 5'd4;
    bus.issue_rd_i = 5'd4;
    #2;
    n_cmp++; if (busy_o !== 32'h0) begin n_bad++; $display("FAIL same_final_busy got=%h exp=0", busy_o); end
    n_cmp++; if (pending_o !== 6'd0) begin n_bad++; $display("FAIL same_final_pending got=%0d exp=0", pending_o); end
    n_cmp++; if (bus.issue_ready_o !== 1'b1) begin n_bad++; $display("FAIL same_final_ready got=%b exp=1", bus.issue_ready_o); end
    e = exp_q.pop_front();
    n_cmp++; if (bus.rs1_data_o !== e) begin n_bad++; $display("FAIL same_final_rs1 got=%h exp=%h", bus.rs1_data_o, e); end
    tick();
  endtask

  task automatic test_reset_midflight;
    logic [31:0] e;
    idle();
    bus.issue_rd_i    = 5'd9;
    bus.issue_valid_i = 1'b1;
    tick();
    idle();
    bus.rs1_addr_i = 5'd5;
    exp_q.push_back(32'hDEAD_BEEF);
    #2;
    n_cmp++; if (busy_o[9] !== 1'b1) begin n_bad++; $display("FAIL mid_busy9 got=%b exp=1", busy_o[9]); end
    e = exp_q.pop_front();
    n_cmp++; if (bus.rs1_data_o !== e) begin n_bad++; $display("FAIL mid_pre_r5 got=%h exp=%h", bus.rs1_data_o, e); end
    arst_ni = 1'b0;
    exp_q.push_back(32'h0);
    #1;
    n_cmp++; if (busy_o !== 32'h0) begin n_bad++; $display("FAIL mid_busy got=%h exp=0", busy_o); end
    n_cmp++; if (pending_o !== 6'd0) begin n_bad++; $display("FAIL mid_pending got=%0d exp=0", pending_o); end
    e = exp_q.pop_front();
    n_cmp++; if (bus.rs1_data_o !== e) begin n_bad++; $display("FAIL mid_r5_cleared got=%h exp=%h", bus.rs1_data_o, e); end
    #3;
    arst_ni = 1'b1;
    tick();
    bus.wb_valid_i = 1'b1;
    bus.wb_rd_i    = 5'd9;
    bus.wb_data_i  = 32'hAB;
    exp_q.push_back(32'hAB);
    tick();
    idle();
    bus.rs1_addr_i = 5'd9;
    #2;
    n_cmp++; if (bus.wb_err_o !== 1'b1) begin n_bad++; $display("FAIL mid_wb_err got=%b exp=1", bus.wb_err_o); end
    e = exp_q.pop_front();
    n_cmp++; if (bus.rs1_data_o !== e) begin n_bad++; $display("FAIL mid_r9 got=%h exp=%h", bus.rs1_data_o, e); end
    tick();
    n_cmp++; if (bus.wb_err_o !== 1'b0) begin n_bad++; $display("FAIL mid_err_len got=%b exp=0", bus.wb_err_o); end
  endtask

  // Bench-side ALU (ADD/SUB/ADDI) with a one-deep write-back pipeline against a golden register model.
  task automatic test_random;
    logic [31:0] m [32];
    logic [31:0] e, a, b, res, imm;
    logic [4:0]  c_rs1, c_rs2, c_rd, f_rd;
    logic [1:0]  op;
    logic [31:0] f_d;
    bit          f_v, hz;
    int          issued, cycles;
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    idle();
    arst_ni = 1'b0;
    #2;
    arst_ni = 1'b1;
    tick();
    f_v = 1'b0; f_rd = '0; f_d = '0;
    issued = 0; cycles = 0;
    c_rs1 = 5'($urandom_range(0, 7)); c_rs2 = 5'($urandom_range(0, 7));
    c_rd  = 5'($urandom_range(1, 7)); op = 2'($urandom_range(0, 2)); imm = $urandom;
    while (issued < 60 && cycles < 1000) begin
      cycles++;
      bus.rs1_addr_i    = c_rs1;
      bus.rs2_addr_i    = c_rs2;
      bus.issue_rd_i    = c_rd;
      bus.issue_valid_i = 1'b1;
      bus.wb_valid_i    = f_v;
      bus.wb_rd_i       = f_rd;
      bus.wb_data_i     = f_d;
`ifdef REG_FILE_SB_BYPASS_EN
      hz = 1'b0;
      a = (f_v && c_rs1 == f_rd && c_rs1 != 0) ? f_d : m[c_rs1];
      b = (f_v && c_rs2 == f_rd && c_rs2 != 0) ? f_d : m[c_rs2];
`else
      hz = f_v && (c_rs1 == f_rd || c_rs2 == f_rd || c_rd == f_rd);
      a = m[c_rs1];
      b = m[c_rs2];
`endif
      exp_q.push_back(a);
      exp_q.push_back(b);
      #2;
      n_cmp++; if (bus.issue_ready_o !== !hz) begin n_bad++; $display("FAIL rnd_ready cyc%0d got=%b exp=%b", cycles, bus.issue_ready_o, !hz); end
      e = exp_q.pop_front();
      n_cmp++; if (bus.rs1_data_o !== e) begin n_bad++; $display("FAIL rnd_rs1 cyc%0d r%0d got=%h exp=%h", cycles, c_rs1, bus.rs1_data_o, e); end
      e = exp_q.pop_front();
      n_cmp++; if (bus.rs2_data_o !== e) begin n_bad++; $display("FAIL rnd_rs2 cyc%0d r%0d got=%h exp=%h", cycles, c_rs2, bus.rs2_data_o, e); end
      case (op)
        2'd0:    res = a + b;
        2'd1:    res = a - b;
        default: res = a + imm;
      endcase
      tick();
      n_cmp++; if (bus.wb_err_o !== 1'b0) begin n_bad++; $display("FAIL rnd_wb_err cyc%0d got=%b exp=0", cycles, bus.wb_err_o); end
      if (f_v) m[f_rd] = f_d;
      if (!hz) begin
        f_v = 1'b1; f_rd = c_rd; f_d = res;
        issued++;
        c_rs1 = 5'($urandom_range(0, 7)); c_rs2 = 5'($urandom_range(0, 7));
        c_rd  = 5'($urandom_range(1, 7)); op = 2'($urandom_range(0, 2)); imm = $urandom;
      end else begin
        f_v = 1'b0;
      end
      n_cmp++; if (pending_o !== 6'(f_v)) begin n_bad++; $display("FAIL rnd_pending cyc%0d got=%0d exp=%0d", cycles, pending_o, f_v); end
    end
    n_cmp++; if (issued < 60) begin n_bad++; $display("FAIL rnd_budget issued=%0d required=60", issued); end
    idle();
    bus.wb_valid_i = f_v;
    bus.wb_rd_i    = f_rd;
    bus.wb_data_i  = f_d;
    tick();
    if (f_v) m[f_rd] = f_d;
    idle();
    n_cmp++; if (pending_o !== 6'd0) begin n_bad++; $display("FAIL rnd_drain_pending got=%0d exp=0", pending_o); end
    for (int r = 1; r < 8; r++) begin
      bus.rs1_addr_i = 5'(r);
      exp_q.push_back(m[r]);
      #2;
      e = exp_q.pop_front();
      n_cmp++; if (bus.rs1_data_o !== e) begin n_bad++; $display("FAIL rnd_final r%0d got=%h exp=%h", r, bus.rs1_data_o, e); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_wb_unreserved();
    test_issue_hazard();
    test_r0();
    test_same_rd();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
